// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, and holds each fetched word with its PC for decode.
// Redirects from execute override any in-flight fetch; stale responses are
// absorbed and discarded.
// Build option: IFU_MISALIGN_TRAP_EN enables a sticky trap state on a
// redirect to a non-word-aligned target.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] redir_tgt;
    logic        capture;

`ifdef IFU_MISALIGN_TRAP_EN
    logic bad_redir;
    // Target is kept verbatim so the trap state reports the offending PC.
    assign redir_tgt = redirect_pc;
    assign bad_redir = redirect_pc[1:0] != 2'b00;
    assign fetch_err = (state == S_ERR);
`else
    // Low bits are dropped: fetch is always word aligned.
    assign redir_tgt = redirect_pc & ~32'h3;
    assign fetch_err = 1'b0;
`endif

    // All handshake outputs decode straight from the state register.
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);

    // A response is only kept when no redirect arrives in the same cycle.
    assign capture = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

    // Next-state and next-PC; redirect overrides every normal transition.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) state_nxt = S_HOLD;
            S_HOLD:  if (inst_ready) begin
                         pc_nxt    = pc + 32'd4;
                         state_nxt = S_REQ;
                     end
            S_DROP:  if (imem_rsp_valid) state_nxt = S_REQ;
            default: state_nxt = state;
        endcase

`ifdef IFU_MISALIGN_TRAP_EN
        if (redirect_valid && state != S_ERR) begin
`else
        if (redirect_valid) begin
`endif
            pc_nxt = redir_tgt;
            case (state)
                // Accepted this cycle means a response is now owed: go absorb it.
                S_REQ:   state_nxt = imem_req_ready ? S_DROP : S_REQ;
                S_WAIT:  state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:  state_nxt = S_REQ;
                // A stale response landing with the redirect is already absorbed.
                S_DROP:  state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                default: state_nxt = state;
            endcase
`ifdef IFU_MISALIGN_TRAP_EN
            // Any outstanding response is silently swallowed in S_ERR.
            if (bad_redir) state_nxt = S_ERR;
`endif
        end
    end

    // State, PC and the instruction holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            inst    <= 32'h0;
            inst_pc <= 32'h0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch. Memory answers every accepted request exactly
// one cycle later with data = ~address.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle response per accepted request.
    logic        pend;
    logic [31:0] paddr;
    always @(posedge clk) begin
        if (rst) begin
            pend  <= 1'b0;
            paddr <= 32'h0;
        end else begin
            pend <= imem_req_valid && imem_req_ready;
            if (imem_req_valid && imem_req_ready) paddr <= imem_req_addr;
        end
    end
    assign imem_rsp_valid = pend;
    assign imem_rsp_data  = ~paddr;

    // Transaction log of accepted requests and consumed instructions.
    logic [31:0] req_q[$];
    logic [31:0] ipc_q[$];
    logic [31:0] idat_q[$];
    int          icyc_q[$];
    int          cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && imem_req_valid && imem_req_ready) req_q.push_back(imem_req_addr);
        if (!rst && inst_valid && inst_ready) begin
            ipc_q.push_back(inst_pc);
            idat_q.push_back(inst);
            icyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_inst(input string tag);
        int n = 0;
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, inst_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_inst, hold_pc;
        int          nreq;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
        chk("rst_addr", imem_req_addr, 32'h8000_0000);

        rst = 1'b0;
        req_q.delete(); ipc_q.delete(); idat_q.delete(); icyc_q.delete();
        chk("req_after_rst", {31'h0, imem_req_valid}, 32'h1);

        // Streaming: three fetches, one per 3 cycles.
        repeat (9) @(negedge clk);
        inst_ready = 1'b0;
        chk("stream_nreq", req_q.size(), 32'd3);
        chk("stream_req0", req_q[0], 32'h8000_0000);
        chk("stream_req1", req_q[1], 32'h8000_0004);
        chk("stream_req2", req_q[2], 32'h8000_0008);
        chk("stream_ninst", ipc_q.size(), 32'd3);
        chk("stream_pc0", ipc_q[0], 32'h8000_0000);
        chk("stream_pc1", ipc_q[1], 32'h8000_0004);
        chk("stream_pc2", ipc_q[2], 32'h8000_0008);
        chk("stream_dat0", idat_q[0], 32'h7FFF_FFFF);
        chk("stream_dat2", idat_q[2], 32'h7FFF_FFF7);
        chk("stream_gap01", icyc_q[1] - icyc_q[0], 32'd3);
        chk("stream_gap12", icyc_q[2] - icyc_q[1], 32'd3);

        // Decode stall: instruction held stable, no new request.
        wait_inst("stall_valid");
        chk("stall_pc", inst_pc, 32'h8000_000C);
        chk("stall_inst", inst, 32'h7FFF_FFF3);
        hold_inst = inst;
        hold_pc   = inst_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_inst_stable", inst, hold_inst);
            chk("stall_pc_stable", inst_pc, hold_pc);
            chk("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("stall_next_req", {31'h0, imem_req_valid}, 32'h1);
        chk("stall_next_addr", imem_req_addr, 32'h8000_0010);

        // Redirect in the cycle after acceptance: stale response dropped.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        inst_ready     = 1'b1;
        ipc_q.delete(); idat_q.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_no_inst", {31'h0, inst_valid}, 32'h0);
        chk("redir_req", {31'h0, imem_req_valid}, 32'h1);
        chk("redir_addr", imem_req_addr, 32'h8000_0100);
        wait_inst("redir_valid");
        chk("redir_stale_dropped", ipc_q.size(), 32'd0);
        chk("redir_pc", inst_pc, 32'h8000_0100);
        chk("redir_inst", inst, 32'h7FFF_FEFF);

        // Redirect coincident with decode handshake: no pc+4.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("hs_redir_consumed", ipc_q.size(), 32'd1);
        chk("hs_redir_no_inst", {31'h0, inst_valid}, 32'h0);
        chk("hs_redir_addr", imem_req_addr, 32'h8000_0200);

        // Redirect while request is being accepted: drop path, then PC wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("drop_no_req", {31'h0, imem_req_valid}, 32'h0);
        chk("drop_no_inst", {31'h0, inst_valid}, 32'h0);
        @(negedge clk);
        chk("drop_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_inst("wrap_valid");
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", inst, 32'h0000_0003);
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);

        // Memory backpressure: request held, then redirected.
        nreq = req_q.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_req_held", {31'h0, imem_req_valid}, 32'h1);
            chk("bp_addr_stable", imem_req_addr, 32'h0000_0000);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("bp_redir_addr", imem_req_addr, 32'h8000_0300);
        chk("bp_no_accept", req_q.size(), nreq);
        imem_req_ready = 1'b1;
        wait_inst("bp_valid");
        chk("bp_pc", inst_pc, 32'h8000_0300);
        chk("bp_inst", inst, 32'h7FFF_FCFF);

        // Misaligned redirect from S_HOLD.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        chk("mis_err", {31'h0, fetch_err}, 32'h1);
        chk("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
        chk("mis_no_inst", {31'h0, inst_valid}, 32'h0);
        nreq = req_q.size();
        repeat (5) @(negedge clk);
        chk("mis_sticky", {31'h0, fetch_err}, 32'h1);
        chk("mis_no_more_req", req_q.size(), nreq);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mis_rst_err", {31'h0, fetch_err}, 32'h0);
        chk("mis_rst_addr", imem_req_addr, 32'h8000_0000);
`else
        chk("mis_err", {31'h0, fetch_err}, 32'h0);
        chk("mis_req", {31'h0, imem_req_valid}, 32'h1);
        chk("mis_addr", imem_req_addr, 32'h8000_0100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
